// File: rtl/therm_enc_pipe.sv
// therm_enc_pipe: 3-stage thermometer-to-binary encoder with optional
// majority bubble correction, code-error flags and a saturating error count.
// Ports: clk, rst_n (async, active low); din/din_valid sample in;
//        err_clr clears err_cnt; dout/dout_valid code out;
//        ovr, bubble_fix, code_err flags; err_cnt errored-sample count.
module therm_enc_pipe #(
   parameter int N_LEVELS  = 15,
   parameter int OUT_W     = 4,
   parameter int BUBBLE_EN = 1,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_LEVELS-1:0]  din,
   input  logic                 din_valid,
   input  logic                 err_clr,
   output logic [OUT_W-1:0]     dout,
   output logic                 dout_valid,
   output logic                 ovr,
   output logic                 bubble_fix,
   output logic                 code_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int CNT_W = $clog2(N_LEVELS + 1);
   localparam logic [CNT_W-1:0] CODE_MAX = CNT_W'(N_LEVELS - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
   localparam logic [N_LEVELS-1:0] ONE = {{(N_LEVELS-1){1'b0}}, 1'b1};

   // stage 1
   logic                v1_q, v1_d;
   logic [N_LEVELS-1:0] t_q, t_d;
   // stage 2
   logic                v2_q, v2_d;
   logic [N_LEVELS-1:0] c_q, c_d;
   logic                ovr2_q, ovr2_d;
   logic                bfix2_q, bfix2_d;
   logic                cerr2_q, cerr2_d;
   // stage 3
   logic                v3_q, v3_d;
   logic [OUT_W-1:0]    dout_q, dout_d;
   logic                ovr_q, ovr_d;
   logic                bfix_q, bfix_d;
   logic                cerr_q, cerr_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;

   // combinational helpers
   logic [N_LEVELS+1:0] te;
   logic [N_LEVELS-1:0] maj;
   logic [N_LEVELS-1:0] c_cmb;
   logic                thermo_ok;
   logic [CNT_W-1:0]    ones;
   logic [CNT_W-1:0]    ones_cl;

   always_comb begin
      // pad with the implied 1 below bit 0 and 0 above the top bit
      te = {1'b0, t_q, 1'b1};
      for (int i = 0; i < N_LEVELS; i++) begin
         maj[i] = (te[i] & te[i+1]) | (te[i] & te[i+2])
                | (te[i+1] & te[i+2]);
      end
      c_cmb = (BUBBLE_EN != 0) ? maj : t_q;
      // 2^k-1 patterns have no set bit shared with their successor
      thermo_ok = ((c_cmb & (c_cmb + ONE)) == '0);

      ones = '0;
      for (int i = 0; i < N_LEVELS; i++) begin
         ones = ones + CNT_W'(c_q[i]);
      end
      // all ones maps to N_LEVELS-1, matching the legacy flash encoding
      ones_cl = (ones > CODE_MAX) ? CODE_MAX : ones;
   end

   always_comb begin
      v1_d    = din_valid;
      t_d     = t_q;
      v2_d    = v1_q;
      c_d     = c_q;
      ovr2_d  = ovr2_q;
      bfix2_d = bfix2_q;
      cerr2_d = cerr2_q;
      v3_d    = v2_q;
      dout_d  = dout_q;
      ovr_d   = ovr_q;
      bfix_d  = bfix_q;
      cerr_d  = cerr_q;
      err_d   = err_q;

      if (din_valid) begin
         t_d = din;
      end

      if (v1_q) begin
         c_d     = c_cmb;
         ovr2_d  = &c_cmb;
         bfix2_d = (BUBBLE_EN != 0) && (c_cmb != t_q) && thermo_ok;
         cerr2_d = !thermo_ok;
      end

      if (v2_q) begin
         dout_d = OUT_W'(ones_cl);
         ovr_d  = ovr2_q;
         bfix_d = bfix2_q;
         cerr_d = cerr2_q;
      end

      if (err_clr) begin
         err_d = '0;
      end else if (v2_q && (bfix2_q || cerr2_q) && (err_q != ERR_MAX)) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         t_q     <= '0;
         v2_q    <= 1'b0;
         c_q     <= '0;
         ovr2_q  <= 1'b0;
         bfix2_q <= 1'b0;
         cerr2_q <= 1'b0;
         v3_q    <= 1'b0;
         dout_q  <= '0;
         ovr_q   <= 1'b0;
         bfix_q  <= 1'b0;
         cerr_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         t_q     <= t_d;
         v2_q    <= v2_d;
         c_q     <= c_d;
         ovr2_q  <= ovr2_d;
         bfix2_q <= bfix2_d;
         cerr2_q <= cerr2_d;
         v3_q    <= v3_d;
         dout_q  <= dout_d;
         ovr_q   <= ovr_d;
         bfix_q  <= bfix_d;
         cerr_q  <= cerr_d;
         err_q   <= err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = v3_q;
   assign ovr        = ovr_q;
   assign bubble_fix = bfix_q;
   assign code_err   = cerr_q;
   assign err_cnt    = err_q;

endmodule

// File: tb/tb_therm_enc_pipe.sv
// tb_therm_enc_pipe: scoreboard bench for therm_enc_pipe, driving one
// default instance and one with BUBBLE_EN=0, ERR_CNT_W=4 in parallel.
module tb_therm_enc_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [14:0] din;
   logic        din_valid;
   logic        err_clr;

   logic [3:0]  dout0, dout1;
   logic        dv0, dv1, ovr0, ovr1, bf0, bf1, ce0, ce1;
   logic [15:0] ec0;
   logic [3:0]  ec1;

   therm_enc_pipe dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .err_clr(err_clr), .dout(dout0), .dout_valid(dv0), .ovr(ovr0),
      .bubble_fix(bf0), .code_err(ce0), .err_cnt(ec0)
   );

   therm_enc_pipe #(.BUBBLE_EN(0), .ERR_CNT_W(4)) dut_nb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .err_clr(err_clr), .dout(dout1), .dout_valid(dv1), .ovr(ovr1),
      .bubble_fix(bf1), .code_err(ce1), .err_cnt(ec1)
   );

   typedef struct packed {
      logic [3:0] dout;
      logic       ovr;
      logic       bf;
      logic       ce;
   } res_t;

   typedef struct {
      int   due;
      res_t r0;
      res_t r1;
   } sb_t;

   sb_t  q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   em0 = 0;
   int   em1 = 0;
   res_t last0 = '0;
   res_t last1 = '0;
   logic clr_s;
   bit   ev;
   sb_t  e;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic res_t model(input logic [14:0] t, input bit be);
      logic [14:0] c;
      int   lo, hi, ones;
      bit   ok;
      res_t r;
      for (int i = 0; i < 15; i++) begin
         if (i == 0) lo = 1;
         else lo = int'(t[i-1]);
         if (i == 14) hi = 0;
         else hi = int'(t[i+1]);
         if (be) c[i] = ((lo + int'(t[i]) + hi) >= 2);
         else c[i] = t[i];
      end
      ones = 0;
      for (int i = 0; i < 15; i++) ones += int'(c[i]);
      ok = 0;
      for (int k = 0; k <= 15; k++) begin
         if (int'(c) == ((1 << k) - 1)) ok = 1;
      end
      r.dout = (ones > 14) ? 4'd14 : 4'(ones);
      r.ovr  = (c == 15'h7FFF);
      r.bf   = be && (c != t) && ok;
      r.ce   = !ok;
      return r;
   endfunction

   // monitor: sample 1 time unit after each rising edge
   always @(posedge clk) begin
      clr_s = err_clr;
      cyc++;
      #1;
      if (rst_n) begin
         ev = (q.size() > 0) && (q[0].due == cyc);
         chk("dv0", 32'(dv0), 32'(ev));
         chk("dv1", 32'(dv1), 32'(ev));
         if (ev) begin
            e = q.pop_front();
            last0 = e.r0;
            last1 = e.r1;
         end
         if (clr_s) begin
            em0 = 0;
            em1 = 0;
         end else if (ev) begin
            if ((e.r0.bf || e.r0.ce) && em0 < 65535) em0++;
            if ((e.r1.bf || e.r1.ce) && em1 < 15) em1++;
         end
         chk("res0", 32'({dout0, ovr0, bf0, ce0}), 32'(last0));
         chk("res1", 32'({dout1, ovr1, bf1, ce1}), 32'(last1));
         chk("err0", 32'(ec0), em0);
         chk("err1", 32'(ec1), em1);
      end
   end

   task automatic send(input logic [14:0] v);
      sb_t s;
      @(negedge clk);
      din = v;
      din_valid = 1'b1;
      s.due = cyc + 3;
      s.r0 = model(v, 1'b1);
      s.r1 = model(v, 1'b0);
      q.push_back(s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din_valid = 1'b0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_0"}, 32'({dv0, dout0, ovr0, bf0, ce0, ec0}), 0);
      chk({tag, "_1"}, 32'({dv1, dout1, ovr1, bf1, ce1, ec1}), 0);
   endtask

   initial begin
      rst_n = 1'b1;
      din = '0;
      din_valid = 1'b0;
      err_clr = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;

      send(15'h0007);
      idle(4);
      send(15'h7FFF);
      send(15'h0000);
      idle(2);
      for (int k = 0; k <= 15; k++) send(15'((32'd1 << k) - 1));
      idle(4);
      send(15'h000B);
      send(15'h0033);
      idle(4);
      repeat (12) begin
         if ($urandom_range(0, 1) == 1) send(15'($urandom));
         else idle(1);
      end
      idle(4);

      repeat (20) send(15'h000B);
      idle(5);
      chk("sat1", 32'(ec1), 15);

      send(15'h000B);
      idle(1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr0", 32'(ec0), 0);
      chk("clr1", 32'(ec1), 0);

      send(15'h000B);
      idle(4);

      send(15'h7FFF);
      send(15'h0007);
      @(negedge clk);
      din_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_zero("arst");
      q.delete();
      em0 = 0;
      em1 = 0;
      last0 = '0;
      last1 = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      send(15'h001F);
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
